// File: rtl/piso_tx_if.sv
// Parallel word handshake into the serial transmitter.
// The source drives din/din_valid and the transmitter answers with din_ready.
interface piso_tx_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out framer: start bit, LSB-first data, stop bit.
// Bit timing comes from a clock-enable divider, not a derived clock.
module piso_tx #(
  parameter int DATA_WIDTH = 4,
  parameter int DIV_MAX    = 33554431
) (
  input  logic   clk,
  input  logic   reset,
  piso_tx_if.slave tx,
  output logic   sout,
  output logic   busy,
  output logic   done
);

  localparam int DW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [DW-1:0] DIV_TOP  = DW'(DIV_MAX);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [DW-1:0]         div, div_nx;
  logic                  sout_nx;
  logic                  busy_nx;
  logic                  done_nx;
  logic                  tick;

  assign tx.din_ready = (state == IDLE);
  assign tick = (state != IDLE) && (div == DIV_TOP);

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      div   <= '0;
      sout  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
      div   <= div_nx;
      sout  <= sout_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  // Next state; sout is derived from the next state so it
  // switches on the same edge as the state itself
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    div_nx   = '0;
    done_nx  = 1'b0;

    if (state != IDLE) begin
      div_nx = tick ? '0 : div + DW'(1);
    end

    unique case (state)
      IDLE: begin
        if (tx.din_valid) begin
          shreg_nx = tx.din;
          cnt_nx   = '0;
          state_nx = START;
        end
      end
      START: begin
        if (tick) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nx = shreg >> 1;
          cnt_nx   = cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
    sout_nx = 1'b1;
    if (state_nx == START) begin
      sout_nx = 1'b0;
    end else if (state_nx == DATA) begin
      sout_nx = shreg_nx[0];
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Randomized check of piso_tx against a timeline model of the frame.
// Expected line level is computed from time since acceptance.
module tb_piso_tx;

  localparam int DWID  = 4;
  localparam int DMAX  = 3;
  localparam int BITC  = DMAX + 1;
  localparam int FRAME = (DWID + 2) * BITC;

  logic clk = 1'b0;
  logic reset;
  logic sout, busy, done;

  piso_tx_if #(.DATA_WIDTH(DWID)) tx ();

  piso_tx #(
    .DATA_WIDTH(DWID),
    .DIV_MAX   (DMAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tx   (tx.slave),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  // Reference: a frame is just "time since acceptance" plus the word
  bit             armed = 1'b0;
  bit             m_act = 1'b0;
  int             m_t   = 0;
  logic [DWID-1:0] m_word = '0;
  bit             m_done = 1'b0;
  int             n_done = 0;

  function automatic logic exp_line(int t, logic [DWID-1:0] w);
    int idx;
    idx = t / BITC;
    if (idx == 0) return 1'b0;
    if (idx <= DWID) return w[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      armed  = 1'b1;
      m_act  = 1'b0;
      m_t    = 0;
      m_done = 1'b0;
      m_word = '0;
    end else begin
      m_done = 1'b0;
      if (m_act) begin
        m_t++;
        if (m_t == FRAME) begin
          m_act  = 1'b0;
          m_done = 1'b1;
          n_done++;
        end
      end else if (tx.din_valid) begin
        m_act  = 1'b1;
        m_t    = 0;
        m_word = tx.din;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("sout", 32'(sout),
          32'(m_act ? exp_line(m_t, m_word) : 1'b1));
      chk("busy", 32'(busy), 32'(m_act));
      chk("done", 32'(done), 32'(m_done));
      chk("ready", 32'(tx.din_ready), 32'(!m_act));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DWID-1:0] w);
    tx.din       = w;
    tx.din_valid = 1'b1;
    step(1);
    tx.din_valid = 1'b0;
  endtask

  int d0;

  initial begin
    reset        = 1'b1;
    tx.din       = '0;
    tx.din_valid = 1'b0;
    step(3);
    reset = 1'b0;
    step(100);
    chk("idle_done_cnt", 32'(n_done), 32'd0);

    send(4'b1011);
    step(FRAME + 2);
    chk("basic_done_cnt", 32'(n_done), 32'd1);

    tx.din       = 4'hB;
    tx.din_valid = 1'b1;
    step(3);
    tx.din = 4'h6;
    step(FRAME);
    tx.din_valid = 1'b0;
    step(FRAME);

    d0           = n_done;
    tx.din       = 4'h5;
    tx.din_valid = 1'b1;
    step(2);
    tx.din = 4'hA;
    step(FRAME + 2);
    tx.din_valid = 1'b0;
    step(FRAME);
    chk("b2b_done_cnt", 32'(n_done - d0), 32'd2);

    d0 = n_done;
    send(4'h9);
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(FRAME + 2);
    chk("abort_no_done", 32'(n_done - d0), 32'd0);

    send(4'h0);
    step(FRAME + 2);
    send(4'hF);
    step(FRAME + 2);
    chk("bound_done_cnt", 32'(n_done - d0), 32'd2);

    for (int f = 0; f < 40; f++) begin
      tx.din       = DWID'($urandom);
      tx.din_valid = 1'b1;
      step($urandom_range(1, 3));
      tx.din_valid = $urandom_range(0, 1) == 1;
      tx.din       = DWID'($urandom);
      step($urandom_range(FRAME - 4, FRAME + 6));
      tx.din_valid = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      step($urandom_range(0, 5));
    end
    step(FRAME + 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, the number of data bits per frame.
REQ-002 SHALL have parameter DIV_MAX, default 33554431, the terminal count of the bit-period divider; one bit lasts DIV_MAX+1 clk cycles.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-005 SHALL have port din, input, DATA_WIDTH bits, the parallel word to transmit.
REQ-006 SHALL have port din_valid, input, 1 bit, asserted when din holds a word to send.
REQ-007 SHALL have port din_ready, output, 1 bit, asserted when the block accepts a word this cycle.
REQ-008 SHALL have port sout, output, 1 bit, the registered serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit, a one-cycle pulse at frame completion.

Function
REQ-011 SHALL use a single clock domain; the divider SHALL produce a one-cycle enable (tick), never a derived clock.
REQ-012 SHALL implement states IDLE, START, DATA and STOP.
REQ-013 din_ready SHALL equal (state==IDLE), combinationally.
REQ-014 A word SHALL be accepted on a rising edge with din_valid && din_ready; on acceptance:
- din latched into the shift register;
- bit counter cleared;
- divider cleared to 0;
- state set to START.
REQ-015 In IDLE the divider SHALL be held at 0.
REQ-016 In other states the divider SHALL count 0..DIV_MAX, wrap to 0, and assert tick in the cycle its value equals DIV_MAX.
REQ-017 sout SHALL follow the state:
- START: 0;
- DATA: shift-register bit 0 (LSB first);
- STOP: 1;
- IDLE: 1.
REQ-018 On tick, state transitions SHALL be:
- START -> DATA;
- in DATA, shift right by one and increment the bit counter;
- DATA -> STOP after DATA_WIDTH data bits;
- STOP -> IDLE.
REQ-019 Each bit SHALL occupy exactly DIV_MAX+1 cycles on sout; a frame SHALL be (DATA_WIDTH+2)*(DIV_MAX+1) cycles.
REQ-020 sout SHALL change on the same edge as the state change (registered output, no extra latency).
REQ-021 done SHALL pulse for one cycle, registered, on the edge where STOP -> IDLE.
REQ-022 busy SHALL be high in START, DATA and STOP.
REQ-023 din_valid during busy SHALL be ignored, with no buffering.
REQ-024 A word presented in the cycle done pulses SHALL be accepted on the next edge, giving back-to-back frames with exactly one idle-high cycle between them.
REQ-025 din changes after acceptance SHALL NOT affect the frame in flight.
REQ-026 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide; the divider SHALL be $clog2(DIV_MAX+1) bits wide and SHALL NOT overflow.

Reset
REQ-027 While reset is high on an edge, the block SHALL set:
- state = IDLE;
- sout = 1;
- busy = 0;
- done = 0;
- divider = 0;
- bit counter = 0;
- shift register = 0.
REQ-028 Reset SHALL take priority over acceptance and ticks, and SHALL abort a frame mid-operation with no done pulse.
REQ-029 din_ready SHALL be high in the first cycle after reset deasserts.

Verification (DIV_MAX=3, DATA_WIDTH=4)
REQ-030 Basic frame: din=4'b1011 accepted at edge k -> sout holds each value for 4 cycles:
- sout=0 from edge k;
- then 1,1,0,1 from edges k+4, k+8, k+12, k+16;
- then 1 (stop bit) from edge k+20;
- done pulses and busy falls at edge k+24.
REQ-031 Busy lockout: din_valid held high with a new din during a frame -> no new acceptance until state is IDLE; the first frame's bits are unchanged.
REQ-032 Back-to-back: din_valid held high continuously with 4'h5 then 4'hA -> second start bit begins exactly one cycle after the done pulse; frames are 0,1,0,1,0,1 then 0,0,1,0,1,1.
REQ-033 Mid-frame reset: reset at edge k+10 -> sout=1, busy=0, done never pulses, din_ready=1 after reset releases.
REQ-034 Boundary data: din=4'h0 and din=4'hF -> the stop bit is still 1 and the frame length is still 24 cycles.
REQ-035 Idle: din_valid=0 for 100 cycles after reset -> sout=1, busy=0, done=0 throughout.
